// File: rtl/dmem_responder.sv
// dmem_responder: CPU data-port responder. Byte-lane storage with sub-word loads/stores,
// word-straddling accesses split into two beats, one-cycle ready pulse and illegal-op flag.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_req, i_we      : access request (sampled in IDLE only), 1=store / 0=load
//   i_addr, i_op     : byte address, size/extension code
//   i_datain         : right-aligned store data
//   o_dataout        : load result (held until the next completed access)
//   o_ready, o_err   : one-cycle completion pulse, illegal-op flag valid with ready
//   o_busy           : high outside IDLE
module dmem_responder #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_datain,
    output logic [31:0] o_dataout,
    output logic        o_ready,
    output logic        o_err,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, BEAT2, RESP} state_t;
    state_t                r_state, w_next;
    logic                  r_we, r_err;
    logic [2:0]            r_op;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_data, r_rd0, r_rd1, r_dout;
    logic [7:0]            r_mem [4][2**ADDR_WIDTH];
    logic                  w_idle, w_legal, w_straddle, w_wen, w_unused;
    logic [2:0]            w_op, w_size;
    logic [1:0]            w_off;
    logic [31:0]           w_data, w_wword, w_rword, w_ext;
    logic [3:0]            w_mask4, w_lanes;
    logic [7:0]            w_be8;
    logic [63:0]           w_wd64, w_shift;
    logic [ADDR_WIDTH-1:0] w_word;
    // In IDLE the access is decoded straight from the inputs (beat 1 happens on the accept edge);
    // in BEAT2 it comes from the latched copy and targets the next word.
    assign w_idle     = r_state == IDLE;
    assign w_op       = w_idle ? i_op : r_op;
    assign w_off      = w_idle ? i_addr[1:0] : r_addr[1:0];
    assign w_data     = w_idle ? i_datain : r_data;
    assign w_word     = w_idle ? i_addr[ADDR_WIDTH+1:2] : r_addr[ADDR_WIDTH+1:2] + ADDR_WIDTH'(1);
    assign w_size     = w_op[1:0] == 2'd0 ? 3'd1 : w_op[1:0] == 2'd1 ? 3'd2 : 3'd4;
    assign w_mask4    = w_op[1:0] == 2'd0 ? 4'b0001 : w_op[1:0] == 2'd1 ? 4'b0011 : 4'b1111;
    assign w_legal    = w_op[1:0] != 2'b11 && w_op != 3'b110;
    assign w_straddle = 3'({1'b0, w_off}) + w_size > 3'd4;
    // Byte enables and data laid out across two consecutive words; low half is beat 1.
    assign w_be8      = {4'b0, w_mask4} << w_off;
    assign w_wd64     = {32'b0, w_data} << {w_off, 3'b000};
    assign w_lanes    = w_idle ? w_be8[3:0] : w_be8[7:4];
    assign w_wword    = w_idle ? w_wd64[31:0] : w_wd64[63:32];
    assign w_wen      = !i_reset && w_legal && (w_idle ? i_req && i_we : r_state == BEAT2 && r_we);
    assign w_rword    = {r_mem[3][w_word], r_mem[2][w_word], r_mem[1][w_word], r_mem[0][w_word]};
    assign w_shift    = {r_rd1, r_rd0} >> {r_addr[1:0], 3'b000};
    assign w_ext      = r_op[1:0] == 2'd0 ? {{24{~r_op[2] & w_shift[7]}}, w_shift[7:0]} :
                        r_op[1:0] == 2'd1 ? {{16{~r_op[2] & w_shift[15]}}, w_shift[15:0]} : w_shift[31:0];
    assign w_unused   = ^{i_addr[31:ADDR_WIDTH+2], w_shift[63:32]};
    always_ff @(posedge i_clock) begin
        for (int l = 0; l < 4; l++)
            if (w_wen && w_lanes[l]) r_mem[l][w_word] <= w_wword[8*l +: 8];
        if (w_idle) r_rd0 <= w_rword;
        if (r_state == BEAT2) r_rd1 <= w_rword;
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_dout  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_idle && i_req) begin
                r_we   <= i_we;
                r_addr <= i_addr[ADDR_WIDTH+1:0];
                r_op   <= i_op;
                r_data <= i_datain;
                r_err  <= !w_legal;
            end
            if (o_ready) r_dout <= o_dataout;
        end
    end
    always_comb begin
        w_next    = r_state == RESP ? IDLE : r_state == BEAT2 ? RESP :
                    !i_req ? IDLE : w_legal && w_straddle ? BEAT2 : RESP;
        o_busy    = !w_idle;
        o_ready   = r_state == RESP;
        o_err     = o_ready && r_err;
        o_dataout = o_ready ? (r_we || r_err ? 32'b0 : w_ext) : r_dout;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services the CPU core's data port: address, op, write-enable and write data. Holds byte-lane synchronous storage with four 8-bit lanes per 32-bit word. Performs sub-word stores with byte enables and sub-word loads with sign or zero extension. Splits word-straddling accesses into two word beats through a small FSM. Signals completion with a one-cycle ready pulse and flags illegal ops.

Parameters:
- ADDR_WIDTH, 15, number of word-index bits. Storage is 2^ADDR_WIDTH words; byte address bits [ADDR_WIDTH+1:2] select the word, upper bits are ignored.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- req  in  1  access request; sampled only in IDLE
- we  in  1  1=store, 0=load
- addr  in  32  byte address
- op  in  3  access size and extension:
  - 000 byte signed
  - 001 half signed
  - 010 word
  - 100 byte unsigned
  - 101 half unsigned
  - stores use size only
- datain  in  32  store data, right-aligned
- dataout  out  32  load result; valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  illegal op; valid with ready
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: FSM=IDLE; dataout=0; ready=0; err=0; busy=0. Storage contents are not cleared by reset.
- States: IDLE, BEAT2, RESP.
- Accept: in IDLE with req=1, the block latches we, addr, op and datain. The requester holds inputs until ready, but they are never re-sampled. req while busy=1 is ignored.
- Decode:
  - size = 1, 2 or 4 bytes from op[1:0]
  - off = addr[1:0]
  - W = word index
  - straddle = off+size > 4
- Illegal op (011, 110, 111): no storage write. State goes to RESP; next cycle ready=1, err=1, dataout=0.
- Aligned (no straddle), accept cycle N:
  - Store: lanes off..off+size-1 of word W are written at the edge ending cycle N. datain byte k goes to lane off+k.
  - Load: word W is read at the same edge.
  - State goes to RESP; ready=1 in cycle N+1.
- Straddle, accept cycle N:
  - Beat 1 (cycle N): lanes off..3 of word W.
  - Beat 2 (cycle N+1, state BEAT2): lanes 0..(off+size-5) of word (W+1) mod 2^ADDR_WIDTH. The word index wraps; the top word followed by word 0 is legal.
  - State goes to RESP; ready=1 in cycle N+2.
- Load assembly: bytes are concatenated little-endian from the beat(s) and shifted right by off. Byte/half results are sign- or zero-extended per op[2]. Word loads are returned unmodified.
- RESP:
  - ready=1 and err valid for exactly one cycle, then IDLE.
  - dataout holds its value until the next completed load. After a store completes, dataout=0.
  - A new request is accepted no earlier than the cycle after RESP. Throughput is 1 access per 2 cycles aligned, per 3 cycles straddled.
- Read-after-write: a load accepted after a store's ready returns the stored data. No bypass is needed beyond this ordering.
- Reset mid-operation: reset in BEAT2 suppresses the beat-2 write and forces IDLE. Beat-1 lanes already written stay written. No ready pulse is issued. reset coincident with req: the request is not accepted.
- Simultaneous req and reset in RESP: reset wins, so ready drops the next cycle.

Test Plan:
- sw 0x12345678 @0x100, then lw @0x100 -> ready one cycle after each accept; dataout=0x12345678, err=0.
- After the above, lb @0x103 -> 0x00000012; lbu @0x100 -> 0x00000078. Then sh 0x8080 @0x100 and lh @0x100 -> 0xFFFF8080; lhu @0x100 -> 0x00008080.
- Word 0x104=0 preset, word 0x100=0x12345678; sw 0xAABBCCDD @0x102 -> ready at N+2. Then lw @0x100=0xCCDD5678, lw @0x104=0x0000AABB, lw @0x102=0xAABBCCDD (ready at N+2).
- Wrap: sh 0xBEEF at the last byte address of storage (word 2^ADDR_WIDTH-1, off=3) -> lane 3 of the top word=0xEF; lane 0 of word 0=0xBE.
- op=011 store @0x100 -> ready=1, err=1, dataout=0; lw @0x100 shows the word unchanged.
- Straddled sw 0xAABBCCDD @0x106 with reset asserted in the BEAT2 cycle -> no ready pulse, busy=0 next cycle. Word 0x104 lanes 2..3 hold 0xCCDD; word 0x108 is unchanged.
